// File: rtl/sisc_mem_resp.sv
// Data-memory responder for the SISC datapath: a 4-phase req/ack slave that
// inserts WAIT_CYC wait states in front of a single-port word array.
module sisc_mem_resp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 8,
  parameter int WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ack,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_busy
);

  localparam int         DEPTH     = 2 ** ADDR_W;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYC);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_ACK    = 2'd3;

  logic [1:0]        state_reg, state_next;
  logic [3:0]        count_reg, count_next;
  logic              we_reg, we_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic              ack_reg, ack_next;
  logic [DATA_W-1:0] rdata_reg;

  logic [DATA_W-1:0] mem_array [DEPTH];

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    we_next    = we_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    ack_next   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (mem_req) begin
          we_next    = mem_we;
          addr_next  = mem_addr;
          wdata_next = mem_wdata;
          count_next = WAIT_INIT;
          state_next = (WAIT_INIT == 4'd0) ? ST_ACCESS : ST_WAIT;
        end
      end
      ST_WAIT: begin
        count_next = count_reg - 4'd1;
        if (count_reg == 4'd1) begin
          state_next = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        state_next = ST_ACK;
      end
      ST_ACK: begin
        // ack is always raised once, even if req already fell before ACK
        if (mem_req || !ack_reg) begin
          ack_next = 1'b1;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_reg <= ST_IDLE;
      count_reg <= 4'd0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      ack_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      we_reg    <= we_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      ack_reg   <= ack_next;
    end
  end

  // Array has no reset; an async reset drops state out of ACCESS, so an
  // interrupted write never lands.
  always_ff @(posedge clk) begin
    if (state_reg == ST_ACCESS && we_reg) begin
      mem_array[addr_reg] <= wdata_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      rdata_reg <= '0;
    end else if (state_reg == ST_ACCESS && !we_reg) begin
      rdata_reg <= mem_array[addr_reg];
    end
  end

  assign mem_ack   = ack_reg;
  assign mem_rdata = rdata_reg;
  assign mem_busy  = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_sisc_mem_resp.sv
// Scoreboard bench: drives the same request stream into a default build and a
// zero-wait build of sisc_mem_resp and checks latency, read data and ack shape.
module tb_sisc_mem_resp;

  localparam int WAIT_D = 2;

  logic        clk;
  logic        rst_f;
  logic        mem_req;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        ack_d, busy_d, ack_z, busy_z;
  logic [31:0] rdata_d, rdata_z;

  sisc_mem_resp #(.DATA_W(32), .ADDR_W(8), .WAIT_CYC(WAIT_D)) u_dut (
    .clk       (clk),
    .rst_f     (rst_f),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (ack_d),
    .mem_rdata (rdata_d),
    .mem_busy  (busy_d)
  );

  sisc_mem_resp #(.DATA_W(32), .ADDR_W(8), .WAIT_CYC(0)) u_dut_nw (
    .clk       (clk),
    .rst_f     (rst_f),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (ack_z),
    .mem_rdata (rdata_z),
    .mem_busy  (busy_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          accept;
    logic [31:0] rdata;
    bit          pulse;
  } exp_t;

  exp_t        q_z[$];
  exp_t        q_d[$];
  logic [31:0] model [256];
  bit          written [256];
  logic [7:0]  wlist[$];
  logic [31:0] last_rd = 32'h0;
  int          checks = 0;
  int          errors = 0;
  int          ntx = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic scramble();
    mem_we    = 1'($urandom);
    mem_addr  = 8'($urandom);
    mem_wdata = $urandom;
  endtask

  task automatic do_txn(input logic we, input logic [7:0] a, input logic [31:0] wd,
                        input int hold, input bit early);
    exp_t e;
    int   t;
    e.accept = cyc + 1;
    e.pulse  = early;
    if (we) begin
      model[a] = wd;
      if (!written[a]) begin
        written[a] = 1'b1;
        wlist.push_back(a);
      end
    end else begin
      last_rd = model[a];
    end
    e.rdata = last_rd;
    q_z.push_back(e);
    q_d.push_back(e);
    $display("TXN %0d %s addr=0x%02h wdata=0x%08h exp_rdata=0x%08h hold=%0d early=%0d",
             ntx, we ? "STR" : "LOD", a, wd, e.rdata, hold, early);
    ntx++;
    mem_req   = 1'b1;
    mem_we    = we;
    mem_addr  = a;
    mem_wdata = wd;
    if (early) begin
      @(negedge clk);
      mem_req = 1'b0;
      scramble();
      t = 0;
      while ((busy_z || busy_d || ack_z || ack_d) && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (t >= 20) begin
        checks++;
        errors++;
        $display("FAIL early_idle_timeout actual=busy still high required=idle within 20 cycles");
      end
    end else begin
      t = 0;
      while (!(ack_z && ack_d) && t < 20) begin
        @(negedge clk);
        t++;
        scramble();
      end
      if (t >= 20) begin
        checks++;
        errors++;
        $display("FAIL ack_timeout actual=ack_nw %0b ack %0b required=both high", ack_z, ack_d);
      end
      repeat (hold) begin
        @(negedge clk);
        chk("hold_ack_nw", 32'(ack_z), 32'd1);
        chk("hold_ack", 32'(ack_d), 32'd1);
        chk("hold_busy", 32'(busy_d), 32'd1);
      end
      mem_req = 1'b0;
      @(negedge clk);
      chk("drop_ack_nw", 32'(ack_z), 32'd0);
      chk("drop_ack", 32'(ack_d), 32'd0);
      chk("drop_busy_nw", 32'(busy_z), 32'd0);
      chk("drop_busy", 32'(busy_d), 32'd0);
    end
    @(negedge clk);
  endtask

  // Monitor: pops one expectation per rising ack on each DUT.
  bit ack_prev [2];
  bit pulse_chk [2];
  int rise_cyc [2];

  always @(negedge clk) begin
    logic        a;
    logic [31:0] r;
    exp_t        e;
    int          lat;
    bit          have;
    for (int d = 0; d < 2; d++) begin
      a   = (d == 0) ? ack_z : ack_d;
      r   = (d == 0) ? rdata_z : rdata_d;
      lat = (d == 0) ? 2 : WAIT_D + 2;
      if (!rst_f) begin
        ack_prev[d]  = 1'b0;
        pulse_chk[d] = 1'b0;
      end else begin
        if (a && !ack_prev[d]) begin
          have = 1'b0;
          if (d == 0 && q_z.size() > 0) begin
            e = q_z.pop_front();
            have = 1'b1;
          end else if (d == 1 && q_d.size() > 0) begin
            e = q_d.pop_front();
            have = 1'b1;
          end
          if (!have) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack dut%0d actual=ack high required=no outstanding request", d);
          end else begin
            chk(d == 0 ? "latency_nw" : "latency", 32'(cyc - e.accept), 32'(lat));
            chk(d == 0 ? "rdata_nw" : "rdata", r, e.rdata);
            pulse_chk[d] = e.pulse;
            rise_cyc[d]  = cyc;
          end
        end
        if (!a && ack_prev[d] && pulse_chk[d]) begin
          chk(d == 0 ? "pulse_len_nw" : "pulse_len", 32'(cyc - rise_cyc[d]), 32'd1);
          pulse_chk[d] = 1'b0;
        end
        ack_prev[d] = a;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=still running required=finish before 100000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       we;
    logic [7:0] a;

    rst_f = 1'b0;
    mem_req = 1'b1;
    scramble();
    #3;
    chk("rst_ack", 32'(ack_d), 32'd0);
    chk("rst_rdata", rdata_d, 32'd0);
    chk("rst_busy", 32'(busy_d), 32'd0);
    chk("rst_ack_nw", 32'(ack_z), 32'd0);
    chk("rst_rdata_nw", rdata_z, 32'd0);
    chk("rst_busy_nw", 32'(busy_z), 32'd0);
    repeat (2) @(negedge clk);
    mem_req = 1'b0;
    rst_f   = 1'b1;
    @(negedge clk);

    do_txn(1'b1, 8'h12, 32'hDEADBEEF, 0, 1'b0);
    do_txn(1'b0, 8'h12, 32'h0, 0, 1'b0);
    do_txn(1'b1, 8'hFF, 32'h1, 0, 1'b0);
    do_txn(1'b0, 8'hFF, 32'h0, 0, 1'b0);
    do_txn(1'b0, 8'h12, 32'h0, 5, 1'b0);
    do_txn(1'b0, 8'hFF, 32'h0, 0, 1'b1);
    do_txn(1'b1, 8'h30, 32'h1234_5678, 0, 1'b1);
    do_txn(1'b0, 8'h30, 32'h0, 1, 1'b0);
    do_txn(1'b1, 8'h05, 32'hA, 0, 1'b0);
    do_txn(1'b0, 8'h05, 32'h0, 0, 1'b0);

    // Reset while the store to address 5 is still pending.
    $display("TXN %0d STR addr=0x05 wdata=0x00000055 aborted by reset", ntx);
    ntx++;
    mem_req   = 1'b1;
    mem_we    = 1'b1;
    mem_addr  = 8'h05;
    mem_wdata = 32'h55;
    @(posedge clk);
    #1;
    chk("pre_rst_busy", 32'(busy_d), 32'd1);
    chk("pre_rst_busy_nw", 32'(busy_z), 32'd1);
    #1;
    rst_f = 1'b0;
    #1;
    chk("async_rst_ack", 32'(ack_d), 32'd0);
    chk("async_rst_rdata", rdata_d, 32'd0);
    chk("async_rst_busy", 32'(busy_d), 32'd0);
    chk("async_rst_ack_nw", 32'(ack_z), 32'd0);
    chk("async_rst_rdata_nw", rdata_z, 32'd0);
    chk("async_rst_busy_nw", 32'(busy_z), 32'd0);
    last_rd = 32'h0;
    @(negedge clk);
    mem_req = 1'b0;
    @(negedge clk);
    rst_f = 1'b1;
    repeat (8) @(negedge clk);
    chk("post_rst_ack", 32'(ack_d), 32'd0);
    chk("post_rst_ack_nw", 32'(ack_z), 32'd0);
    do_txn(1'b0, 8'h05, 32'h0, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      we = (wlist.size() == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (we) a = 8'($urandom_range(0, 255));
      else    a = wlist[$urandom_range(0, wlist.size() - 1)];
      do_txn(we, a, $urandom, $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
    end

    repeat (5) @(negedge clk);
    chk("sb_drain_nw", 32'(q_z.size()), 32'd0);
    chk("sb_drain", 32'(q_d.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
